// File: rtl/usb_sample_streamer.sv
// usb_sample_streamer
// Buffers 32-bit words from the USB read path and plays each word out as four
// signed 8-bit samples (byte 0 first) at a programmable rate, holding the last
// sample between updates. The FIFO head word lives in a prefetch register so
// a new sample can be produced every cycle at rate_div=0.
// Occupancy ('level') counts every stored word, including the head word that
// is currently being played. The head word leaves the FIFO when its byte 3 is
// emitted.
module usb_sample_streamer #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned AFULL_SLACK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           usb_rd_data,
    input  logic                  usb_rd_data_valid,
    output logic                  usb_rd_full,
    input  logic                  enable,
    input  logic [15:0]           rate_div,
    input  logic [DEPTH_LOG2:0]   start_level,
    input  logic                  clear_stats,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic [31:0]           underrun_count,
    output logic [31:0]           overflow_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_AFULL = (DEPTH_LOG2+1)'(DEPTH - AFULL_SLACK);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_PLAY    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [31:0]           r_head;
    logic [1:0]            r_byte_idx;
    logic [15:0]           r_tick_cnt;
    logic [7:0]            r_out_data;
    logic                  r_out_valid;
    logic                  r_full;
    logic [31:0]           r_underrun_cnt;
    logic [31:0]           r_overflow_cnt;

    logic                  w_flush;
    logic                  w_tick;
    logic                  w_underrun;
    logic                  w_emit;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_wr_head;
    logic                  w_wr_mem;
    logic                  w_head_from_mem;
    logic [7:0]            w_byte;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: enable drop flushes, tick/underrun generation in PLAY
    always_comb begin
        w_state_next = r_state;
        w_flush      = 1'b0;
        w_tick       = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (!enable) begin
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end else if ((r_level >= start_level) && (r_level != '0)) begin
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!enable) begin
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_tick_cnt >= rate_div) begin
                    w_tick = 1'b1;
                    // Only a word boundary can starve; a started word always finishes
                    if ((r_byte_idx == 2'd0) && (r_level == '0)) begin
                        w_underrun   = 1'b1;
                        w_state_next = S_PREFILL;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FIFO control decode and current-byte select
    always_comb begin
        w_emit          = w_tick && !w_underrun;
        w_pop           = w_emit && (r_byte_idx == 2'd3);
        w_wr            = usb_rd_data_valid && !w_flush && (r_level != LVL_FULL);
        w_drop          = usb_rd_data_valid && !w_flush && (r_level == LVL_FULL);
        // Incoming word goes straight to the head register when it becomes the head
        w_wr_head       = w_wr && ((r_level == '0) || (w_pop && (r_level == LVL_ONE)));
        w_wr_mem        = w_wr && !w_wr_head;
        w_head_from_mem = w_pop && (r_level > LVL_ONE);
        case (r_byte_idx)
            2'd0:    w_byte = r_head[7:0];
            2'd1:    w_byte = r_head[15:8];
            2'd2:    w_byte = r_head[23:16];
            default: w_byte = r_head[31:24];
        endcase
    end

    // Backing storage for words behind the head
    always_ff @(posedge clk) begin
        if (w_wr_mem) begin
            r_mem[r_wr_ptr] <= usb_rd_data;
        end
    end

    // Pointers and occupancy; a flush empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_mem) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_head_from_mem) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - LVL_ONE;
            end
        end
    end

    // Prefetch register holding the head word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
        end else if (w_wr_head) begin
            r_head <= usb_rd_data;
        end else if (w_head_from_mem) begin
            r_head <= r_mem[r_rd_ptr];
        end
    end

    // Sample period counter, only runs in PLAY
    always_ff @(posedge clk) begin
        if (reset || (r_state != S_PLAY) || !enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // Byte position within the head word
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_byte_idx <= '0;
        end else if (w_emit) begin
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    // Sample output register with zero-order hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_tick;
            if (w_flush || (r_state == S_IDLE) || w_underrun) begin
                r_out_data <= '0;
            end else if (w_emit) begin
                r_out_data <= w_byte;
            end
        end
    end

    // Registered almost-full flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
        end else begin
            r_full <= (r_level >= LVL_AFULL);
        end
    end

    // Saturating event counters; clear_stats overrides a same-cycle event
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            r_underrun_cnt <= '0;
            r_overflow_cnt <= '0;
        end else begin
            if (w_underrun && (r_underrun_cnt != '1)) begin
                r_underrun_cnt <= r_underrun_cnt + 32'd1;
            end
            if (w_drop && (r_overflow_cnt != '1)) begin
                r_overflow_cnt <= r_overflow_cnt + 32'd1;
            end
        end
    end

    assign usb_rd_full    = r_full;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign level          = r_level;
    assign underrun_count = r_underrun_cnt;
    assign overflow_count = r_overflow_cnt;

endmodule

// File: tb/tb_usb_sample_streamer.sv
// Testbench for usb_sample_streamer: directed vector table, hand-written
// corner sequences and randomized traffic, all checked against a queue-based
// behavioural model of the streamer.
module tb_usb_sample_streamer;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int SLACK = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   usb_rd_data;
    logic          usb_rd_data_valid;
    logic          usb_rd_full;
    logic          enable;
    logic [15:0]   rate_div;
    logic [DL:0]   start_level;
    logic          clear_stats;
    logic [7:0]    out_data;
    logic          out_valid;
    logic [DL:0]   level;
    logic [31:0]   underrun_count;
    logic [31:0]   overflow_count;

    int n_checks = 0;
    int n_fail   = 0;

    usb_sample_streamer #(
        .DEPTH_LOG2 (DL),
        .AFULL_SLACK(SLACK)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .usb_rd_data      (usb_rd_data),
        .usb_rd_data_valid(usb_rd_data_valid),
        .usb_rd_full      (usb_rd_full),
        .enable           (enable),
        .rate_div         (rate_div),
        .start_level      (start_level),
        .clear_stats      (clear_stats),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .level            (level),
        .underrun_count   (underrun_count),
        .overflow_count   (overflow_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: a word queue plus a play position
    typedef enum int {M_IDLE, M_WAIT, M_RUN} mmode_t;
    logic [31:0] m_q[$];
    mmode_t      m_mode;
    int          m_bidx;
    int          m_cnt;
    logic [7:0]  m_od;
    logic        m_ov;
    logic        m_full;
    logic [31:0] m_und;
    logic [31:0] m_ovf;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Advance the model by one clock using the inputs currently applied
    function automatic void model_step();
        int         lvl;
        mmode_t     mode0;
        bit         tick;
        bit         under;
        logic [31:0] w;
        lvl   = m_q.size();
        mode0 = m_mode;
        if (reset) begin
            m_q.delete();
            m_mode = M_IDLE; m_bidx = 0; m_cnt = 0;
            m_od = 0; m_ov = 0; m_full = 0; m_und = 0; m_ovf = 0;
            return;
        end
        m_ov   = 0;
        m_full = (lvl >= DEPTH - SLACK);
        if (clear_stats) begin
            // applied at the end, after any event of this cycle
        end
        if (mode0 != M_IDLE && !enable) begin
            m_q.delete();
            m_mode = M_IDLE; m_bidx = 0; m_cnt = 0; m_od = 0;
            if (clear_stats) begin m_und = 0; m_ovf = 0; end
            return;
        end
        tick  = (mode0 == M_RUN) && (m_cnt >= int'(rate_div));
        under = tick && (m_bidx == 0) && (lvl == 0);
        m_cnt = (mode0 == M_RUN && !tick) ? m_cnt + 1 : 0;
        if (tick) begin
            m_ov = 1;
            if (under) begin
                m_od   = 0;
                m_mode = M_WAIT;
                if (m_und != 32'hFFFF_FFFF) m_und = m_und + 1;
            end else begin
                w    = m_q[0];
                m_od = w[8*m_bidx +: 8];
                if (m_bidx == 3) begin
                    void'(m_q.pop_front());
                    m_bidx = 0;
                end else begin
                    m_bidx++;
                end
            end
        end
        if (usb_rd_data_valid) begin
            if (lvl < DEPTH) m_q.push_back(usb_rd_data);
            else if (m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 1;
        end
        if (mode0 == M_IDLE) begin
            m_od = 0;
            if (enable) m_mode = M_WAIT;
        end else if (mode0 == M_WAIT) begin
            if (lvl >= int'(start_level) && lvl > 0) m_mode = M_RUN;
        end
        if (clear_stats) begin m_und = 0; m_ovf = 0; end
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("m_out_data",  32'(out_data),       32'(m_od));
        chk("m_out_valid", 32'(out_valid),      32'(m_ov));
        chk("m_level",     32'(level),          32'(m_q.size()));
        chk("m_rd_full",   32'(usb_rd_full),    32'(m_full));
        chk("m_underrun",  underrun_count,      m_und);
        chk("m_overflow",  overflow_count,      m_ovf);
    endtask

    typedef struct {
        bit          en;
        bit          vld;
        logic [31:0] d;
        bit          eov;
        logic [7:0]  eod;
        int          elvl;
        int          eund;
    } vec_t;

    vec_t tbl[24];

    initial begin
        // Basic play: rate_div=3, start_level=1, one word
        tbl[0]  = '{1'b0, 1'b1, 32'h0403_0201, 1'b0, 8'h00, 1, 0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1, 0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1, 0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1, 0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 8'h01, 1, 0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h01, 1, 0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h01, 1, 0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h01, 1, 0};
        tbl[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 8'h02, 1, 0};
        tbl[11] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h02, 1, 0};
        tbl[12] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h02, 1, 0};
        tbl[13] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h02, 1, 0};
        tbl[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 8'h03, 1, 0};
        tbl[15] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h03, 1, 0};
        tbl[16] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h03, 1, 0};
        tbl[17] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h03, 1, 0};
        tbl[18] = '{1'b1, 1'b0, 32'h0, 1'b1, 8'h04, 0, 0};
        tbl[19] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h04, 0, 0};
        tbl[20] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h04, 0, 0};
        tbl[21] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h04, 0, 0};
        tbl[22] = '{1'b1, 1'b0, 32'h0, 1'b1, 8'h00, 0, 1};
        tbl[23] = '{1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 0, 1};

        reset = 1'b1; enable = 1'b0; usb_rd_data_valid = 1'b0; usb_rd_data = '0;
        rate_div = 16'd3; start_level = 5'd1; clear_stats = 1'b0;
        cycle();
        cycle();
        chk("rst_out_data",  32'(out_data),    32'h0);
        chk("rst_out_valid", 32'(out_valid),   32'h0);
        chk("rst_level",     32'(level),       32'h0);
        chk("rst_full",      32'(usb_rd_full), 32'h0);
        chk("rst_underrun",  underrun_count,   32'h0);
        chk("rst_overflow",  overflow_count,   32'h0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            enable            = tbl[i].en;
            usb_rd_data_valid = tbl[i].vld;
            usb_rd_data       = tbl[i].d;
            cycle();
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].eov));
            chk("tbl_out_data",  32'(out_data),  32'(tbl[i].eod));
            chk("tbl_level",     32'(level),     32'(tbl[i].elvl));
            chk("tbl_underrun",  underrun_count, 32'(tbl[i].eund));
        end

        // Gapless playback of four preloaded words at rate_div=0
        enable = 1'b0; usb_rd_data_valid = 1'b0; rate_div = 16'd0; start_level = 5'd1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            usb_rd_data_valid = 1'b1;
            usb_rd_data = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
            cycle();
        end
        usb_rd_data_valid = 1'b0;
        chk("gap_level", 32'(level), 32'd4);
        enable = 1'b1;
        cycle();
        cycle();
        for (int n = 0; n < 16; n++) begin
            cycle();
            chk("gap_valid", 32'(out_valid), 32'h1);
            chk("gap_data",  32'(out_data),  32'(n + 1));
        end
        cycle();
        chk("gap_und_valid", 32'(out_valid), 32'h1);
        chk("gap_und_data",  32'(out_data),  32'h0);
        chk("gap_und_count", underrun_count, 32'd2);
        cycle();
        chk("gap_prefill_idle", 32'(out_valid), 32'h0);

        // Backpressure and overflow with playback disabled
        enable = 1'b0;
        cycle();
        for (int k = 1; k <= 20; k++) begin
            usb_rd_data_valid = 1'b1;
            usb_rd_data = $urandom();
            cycle();
            chk("ovf_level", 32'(level),       32'((k < 16) ? k : 16));
            chk("ovf_full",  32'(usb_rd_full), 32'(k >= 9));
        end
        chk("ovf_count", overflow_count, 32'd4);
        usb_rd_data_valid = 1'b0;

        // Prefill gating with start_level=3
        start_level = 5'd3; rate_div = 16'd0;
        enable = 1'b1; cycle();
        enable = 1'b0; cycle();
        chk("gate_flush_level", 32'(level), 32'h0);
        enable = 1'b1;
        usb_rd_data_valid = 1'b1; usb_rd_data = 32'h4433_2211; cycle();
        usb_rd_data = 32'h5A5A_5A5A; cycle();
        usb_rd_data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("gate_no_valid", 32'(out_valid), 32'h0);
        end
        usb_rd_data_valid = 1'b1; usb_rd_data = 32'hA5A5_A5A5; cycle();
        usb_rd_data_valid = 1'b0;
        chk("gate_level3", 32'(level), 32'd3);
        cycle();
        chk("gate_enter_play", 32'(out_valid), 32'h0);
        cycle();
        chk("gate_first_valid", 32'(out_valid), 32'h1);
        chk("gate_first_data",  32'(out_data),  32'h11);
        cycle();
        chk("gate_second_data", 32'(out_data),  32'h22);

        // Disable mid-word with a coincident write
        enable = 1'b0; usb_rd_data_valid = 1'b1; usb_rd_data = 32'hDEAD_BEEF;
        cycle();
        usb_rd_data_valid = 1'b0;
        chk("dis_level",    32'(level),     32'h0);
        chk("dis_data",     32'(out_data),  32'h0);
        chk("dis_valid",    32'(out_valid), 32'h0);
        chk("dis_overflow", overflow_count, 32'd4);

        // clear_stats coincident with an underrun
        start_level = 5'd1; rate_div = 16'd0;
        usb_rd_data_valid = 1'b1; usb_rd_data = 32'h8877_6655; cycle();
        usb_rd_data_valid = 1'b0; enable = 1'b1;
        cycle();
        cycle();
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("clr_data", 32'(out_data), 32'(8'h55 + 8'(n * 8'h11)));
        end
        chk("clr_und_before", underrun_count, 32'd2);
        clear_stats = 1'b1;
        cycle();
        clear_stats = 1'b0;
        chk("clr_und_valid", 32'(out_valid), 32'h1);
        chk("clr_und_data",  32'(out_data),  32'h0);
        chk("clr_und_count", underrun_count, 32'h0);
        chk("clr_ovf_count", overflow_count, 32'h0);

        // Reset while playing
        rate_div = 16'd3;
        usb_rd_data_valid = 1'b1; usb_rd_data = 32'h0D0C_0B0A; cycle();
        usb_rd_data = 32'h1111_1111; cycle();
        usb_rd_data_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("rp_play_data", 32'(out_data), 32'h0A);
        cycle();
        reset = 1'b1;
        cycle();
        chk("rp_data",  32'(out_data),    32'h0);
        chk("rp_valid", 32'(out_valid),   32'h0);
        chk("rp_level", 32'(level),       32'h0);
        chk("rp_full",  32'(usb_rd_full), 32'h0);
        reset = 1'b0;

        // Randomized traffic against the model
        begin
            int dens;
            dens = 3;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 63) == 0) dens = int'($urandom_range(0, 7));
                if ($urandom_range(0, 99) == 0) rate_div = 16'($urandom_range(0, 4));
                if ($urandom_range(0, 99) == 0) start_level = 5'($urandom_range(0, 6));
                enable            = ($urandom_range(0, 39) != 0);
                usb_rd_data_valid = (int'($urandom_range(0, 7)) < dens);
                usb_rd_data       = $urandom();
                clear_stats       = ($urandom_range(0, 199) == 0);
                reset             = ($urandom_range(0, 799) == 0);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_sample_streamer.md
Name: usb_sample_streamer

Overview:
Upstream source stage for dds_block. It buffers 32-bit words from the USB read path in a local FIFO and unpacks each word into four signed 8-bit samples. Samples are played out at a programmable rate with zero-order hold. The output drives dds_block's aud_in (or raw) sample input; the block reports fill level, underruns and overflows for the register file.

Parameters:
DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 32-bit words
AFULL_SLACK, 8, usb_rd_full asserts when free words <= AFULL_SLACK

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
usb_rd_data  in  32  packed samples, byte 0 = [7:0] played first
usb_rd_data_valid  in  1  write strobe for usb_rd_data
usb_rd_full  out  1  registered almost-full backpressure to USB side
enable  in  1  level-sensitive play enable
rate_div  in  16  sample period = rate_div+1 clk cycles
start_level  in  DEPTH_LOG2+1  words required before play starts
clear_stats  in  1  synchronous clear of both counters
out_data  out  8  signed sample, held between updates
out_valid  out  1  one-cycle pulse when out_data updates
level  out  DEPTH_LOG2+1  FIFO occupancy in words
underrun_count  out  32  saturating underrun event count
overflow_count  out  32  saturating dropped-word count

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state IDLE, FIFO empty, byte index 0.
  - out_data=0, out_valid=0, usb_rd_full=0, level=0.
  - both counters=0, tick counter=0.
- Write side:
  - Word is stored when usb_rd_data_valid=1 and level < 2^DEPTH_LOG2.
  - If valid while the FIFO is completely full, the word is dropped and overflow_count increments.
  - Writes are accepted in every state.
- Level and backpressure:
  - A write in cycle N is reflected in level at N+1.
  - A simultaneous write and pop leaves level unchanged.
  - usb_rd_full is registered from level >= 2^DEPTH_LOG2 - AFULL_SLACK (one-cycle lag).
- State machine:
  - IDLE: out_data=0, tick counter held 0. enable=1 -> PREFILL.
  - PREFILL: out_data holds its last value. level >= start_level and level>0 -> PLAY.
  - PLAY: tick counter counts 0 up; a tick occurs when count >= rate_div, then count returns to 0. Using >= means a rate_div reduction never wraps.
  - On each tick, the current byte is emitted and the byte index advances 0->1->2->3. After byte 3, the next word is popped.
  - enable=0 in any state -> IDLE next cycle. That transition flushes the FIFO once (level=0, byte index 0, out_data=0); writes in that same cycle are discarded and not counted.
- Prefetch: the head word is held in a prefetch register, so the output is gapless at rate_div=0 (a new sample every cycle) while data remains.
- Underrun:
  - Occurs on a tick at a word boundary with no word available.
  - Response: out_data=0, out_valid=1, underrun_count+1, state -> PREFILL.
  - A partially consumed word never underruns mid-word.
- Latency: tick in cycle N -> out_data/out_valid valid in cycle N+1. First tick occurs rate_div+1 cycles after entering PLAY.
- Counters:
  - Both saturate at 0xFFFFFFFF.
  - clear_stats wins over a same-cycle increment.
- Reset mid-operation: identical to the power-on reset values, regardless of state or pending tick.

Test Plan:
- Basic play: rate_div=3, start_level=1, write 0x04_03_02_01, enable -> out_data 01,02,03,04 with out_valid every 4 cycles; first pulse 5 cycles after PLAY entry.
- Gapless: rate_div=0, preload 4 words, enable -> 16 consecutive out_valid cycles, bytes in order; 17th tick underruns with out_data=0, underrun_count=1, state PREFILL.
- Backpressure/overflow: DEPTH_LOG2=4, enable=0, write 20 words back-to-back -> usb_rd_full rises the cycle after level=8; level stops at 16; overflow_count=4.
- Prefill gating: start_level=3, write 2 words, enable -> no out_valid; third write -> playback starts.
- Disable mid-word: stop enable after byte 1 of a word -> next cycle level=0, out_data=0; a same-cycle write is discarded with overflow_count unchanged.
- Stats/reset: clear_stats coincident with an underrun -> underrun_count=0; assert reset during PLAY -> all outputs 0, state IDLE.
